// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int MIN_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;

    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word fall-through FIFO holding bytes waiting to be sent.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok;
    logic             pop_ok;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push_i && (level_q != LW'(DEPTH));
    assign pop_ok  = pop_i && (level_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO front end, frame FSM with latched baud divisor.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PARITY_EN = 0,
    parameter int DIV_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [DIV_WIDTH-1:0]     div_i,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [LW-1:0]          level;
    logic [DATA_BITS-1:0]   fifo_data;
    logic                   push;
    logic                   pop;
    logic                   start;

    tx_state_e              state_q, state_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic [DIV_WIDTH-1:0]   div_eff;
    logic                   bit_done;
    logic                   fifo_nonempty;

    assign ready_o       = (level < LW'(DEPTH));
    assign push          = valid_i & ready_o;
    assign fifo_nonempty = (level != '0);
    assign div_eff       = (div_i < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div_i;
    assign bit_done      = (cnt_q == '0);

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (data_i),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .level_o (level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        start   = 1'b0;

        if (state_q != ST_IDLE && !bit_done) begin
            cnt_d = cnt_q - 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                start = fifo_nonempty;
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    cnt_d   = div_q - 1'b1;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d = div_q - 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_BIT_IDX) begin
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Shift register always presents the current bit at [0].
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    cnt_d   = div_q - 1'b1;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (fifo_nonempty) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame launch: pop the head entry and latch the divisor for the whole frame.
        if (start) begin
            pop     = 1'b1;
            state_d = ST_START;
            div_d   = div_eff;
            cnt_d   = div_eff - 1'b1;
            idx_d   = '0;
            shreg_d = fifo_data;
            par_d   = ^fifo_data;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o    = tx_q;
    assign busy_o  = (state_q != ST_IDLE) || fifo_nonempty;
    assign level_o = level;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench: two transmitters (no parity / parity) against a frame-level model.
module tb_uart_tx_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic [15:0] div_v;
    logic        valid_a, valid_b;
    logic        ready_a, tx_a, busy_a;
    logic        ready_b, tx_b, busy_b;
    logic [3:0]  level_a;
    logic [2:0]  level_b;

    int n_assert = 0;
    int n_fail   = 0;
    int sel      = 0;

    byte unsigned exp_a[$];
    byte unsigned exp_b[$];

    logic cur_tx, cur_ready, cur_busy;
    int   cur_level;

    always #5 clk = ~clk;

    uart_tx_buf #(.DEPTH(8), .PARITY_EN(0), .DIV_WIDTH(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid_a), .ready_o(ready_a),
        .div_i(div_v), .tx_o(tx_a), .busy_o(busy_a), .level_o(level_a)
    );

    uart_tx_buf #(.DEPTH(4), .PARITY_EN(1), .DIV_WIDTH(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid_b), .ready_o(ready_b),
        .div_i(div_v), .tx_o(tx_b), .busy_o(busy_b), .level_o(level_b)
    );

    always_comb begin
        if (sel == 0) begin
            cur_tx = tx_a; cur_ready = ready_a; cur_busy = busy_a; cur_level = int'(level_a);
        end else begin
            cur_tx = tx_b; cur_ready = ready_b; cur_busy = busy_b; cur_level = int'(level_b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input int s, input logic v);
        if (s == 0) valid_a = v;
        else        valid_b = v;
    endtask

    // Presents bytes with valid held; each is recorded as expected once ready is seen.
    task automatic push_burst(input int s, input byte unsigned bytes[$], output int cycles);
        int g;
        cycles = 0;
        foreach (bytes[i]) begin
            data = bytes[i];
            set_valid(s, 1'b1);
            g = 0;
            while (!cur_ready && g < 3000) begin
                @(negedge clk);
                g++;
                cycles++;
            end
            check("push_wait", (g < 3000), 1);
            if (cur_ready) begin
                if (s == 0) exp_a.push_back(bytes[i]);
                else        exp_b.push_back(bytes[i]);
            end
            @(negedge clk);
            cycles++;
        end
        set_valid(s, 1'b0);
    endtask

    // Walks the line cycle by cycle, expecting nframes contiguous frames then idle.
    task automatic check_frames(input int s, input int nframes, input string tag);
        int g, bad, blen;
        byte unsigned b;
        logic bits[$];
        g = 0;
        while (cur_tx !== 1'b0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_start"}, cur_tx, 0);
        for (int f = 0; f < nframes; f++) begin
            b = 8'h00;
            if (s == 0) begin
                check({tag, "_model_q"}, (exp_a.size() > 0), 1);
                if (exp_a.size() > 0) b = exp_a.pop_front();
            end else begin
                check({tag, "_model_q"}, (exp_b.size() > 0), 1);
                if (exp_b.size() > 0) b = exp_b.pop_front();
            end
            blen = (div_v < 16'd4) ? 4 : int'(div_v);
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(b[i]);
            if (s == 1) bits.push_back(^b);
            bits.push_back(1'b1);
            bad = 0;
            foreach (bits[k]) begin
                for (int c = 0; c < blen; c++) begin
                    if (cur_tx !== bits[k]) bad++;
                    if (cur_busy !== 1'b1) bad++;
                    @(negedge clk);
                end
            end
            check($sformatf("%s_frame%0d_%02h", tag, f, b), bad, 0);
        end
        check({tag, "_idle_tx"}, cur_tx, 1);
        check({tag, "_idle_busy"}, cur_busy, 0);
        check({tag, "_idle_level"}, cur_level, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned q[$];
        int cyc, lows, n;

        rst = 1'b1; data = 8'h00; div_v = 16'd8; valid_a = 1'b0; valid_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_a", tx_a, 1);
        check("rst_ready_a", ready_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_level_a", level_a, 0);
        check("rst_tx_b", tx_b, 1);
        check("rst_ready_b", ready_b, 1);
        check("rst_busy_b", busy_b, 0);
        check("rst_level_b", level_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // Idle push of 0xA5: busy at the handshake edge, line falls one edge later.
        sel = 0; div_v = 16'd8;
        data = 8'hA5; valid_a = 1'b1;
        check("a5_ready", ready_a, 1);
        exp_a.push_back(8'hA5);
        @(negedge clk);
        valid_a = 1'b0;
        check("a5_busy_k", busy_a, 1);
        check("a5_tx_k", tx_a, 1);
        check("a5_level_k", level_a, 1);
        @(negedge clk);
        check("a5_tx_k1", tx_a, 0);
        check("a5_level_k1", level_a, 0);
        check_frames(0, 1, "a5");

        // 0x55 at divisor 8: alternating line, 80 cycles.
        q = '{8'h55};
        push_burst(0, q, cyc);
        check_frames(0, 1, "x55");

        // Divisor below the minimum clamps to 4 cycles per bit.
        div_v = 16'd2;
        q = '{8'($urandom_range(0, 255))};
        push_burst(0, q, cyc);
        check_frames(0, 1, "div2");

        // Random bursts at random divisors, frames must be contiguous.
        for (int r = 0; r < 3; r++) begin
            div_v = 16'($urandom_range(0, 12));
            n = $urandom_range(1, 5);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            fork
                push_burst(0, q, cyc);
                check_frames(0, n, $sformatf("rnd%0d", r));
            join
        end

        // Fill: 9 taken at once, then stall until the first frame ends.
        div_v = 16'd4;
        q.delete();
        for (int i = 0; i < 9; i++) q.push_back(8'($urandom));
        fork
            begin
                byte unsigned q10[$];
                int c2;
                push_burst(0, q, cyc);
                check("fill_cycles", cyc, 9);
                check("fill_ready", ready_a, 0);
                check("fill_level", level_a, 8);
                check("fill_busy", busy_a, 1);
                q10 = '{8'hC3};
                push_burst(0, q10, c2);
            end
            check_frames(0, 10, "fill");
        join

        // Divisor change mid-frame affects only the next frame.
        div_v = 16'd8;
        q = '{8'h3A, 8'hE1};
        fork
            push_burst(0, q, cyc);
            check_frames(0, 2, "divchg");
            begin
                repeat (20) @(negedge clk);
                div_v = 16'd16;
            end
        join

        // Reset during data bit 3 with a queue: frame abandoned, FIFO flushed.
        div_v = 16'd8;
        q = '{8'h00, 8'h11, 8'h22, 8'h33};
        push_burst(0, q, cyc);
        repeat (34) @(negedge clk);
        check("mid_tx_low_frame", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", tx_a, 1);
        check("mid_rst_level", level_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_ready", ready_a, 1);
        rst = 1'b0;
        exp_a.delete();
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
        end
        check("mid_rst_quiet", lows, 0);

        // Handshake during reset is dropped.
        data = 8'h3C; valid_a = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; valid_a = 1'b0;
        check("rst_hs_level", level_a, 0);
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
        end
        check("rst_hs_quiet", lows, 0);

        // Parity instance: 0x07 -> parity 1 (88 cycles), 0x03 -> parity 0.
        sel = 1; div_v = 16'd8;
        q = '{8'h07};
        push_burst(1, q, cyc);
        check_frames(1, 1, "par07");
        q = '{8'h03};
        push_burst(1, q, cyc);
        check_frames(1, 1, "par03");

        // Parity instance, DEPTH 4: 5 taken at once, sixth after the first frame.
        div_v = 16'($urandom_range(4, 7));
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        fork
            begin
                byte unsigned q6[$];
                int c2;
                push_burst(1, q, cyc);
                check("bfill_cycles", cyc, 5);
                check("bfill_ready", ready_b, 0);
                check("bfill_level", level_b, 4);
                q6 = '{8'($urandom)};
                push_burst(1, q6, c2);
            end
            check_frames(1, 6, "bfill");
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter PARITY_EN, default 0, meaning 1 appends an even-parity bit after the data bits.
REQ-003 The block SHALL have parameter DIV_WIDTH, default 16, meaning the width of the baud divisor.
REQ-004 The block SHALL have port clk_i  input  1  clock; all logic SHALL be on its rising edge (one clock).
REQ-005 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port data_i  input  8  byte to transmit.
REQ-007 The block SHALL have port valid_i  input  1  data_i valid.
REQ-008 The block SHALL have port ready_o  output  1  FIFO can accept data_i; handshake = valid_i & ready_o at a rising edge.
REQ-009 The block SHALL have port div_i  input  DIV_WIDTH  clk_i cycles per UART bit.
REQ-010 The block SHALL have port tx_o  output  1  serial line, idles high.
REQ-011 The block SHALL have port busy_o  output  1  frame in progress or FIFO non-empty.
REQ-012 The block SHALL have port level_o  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-013 The frame SHALL be 1 start bit (0), 8 data bits LSB first, an optional parity bit (XOR of the data bits, so the data plus parity bit XOR to 0), and 1 stop bit (1).
REQ-014 Each bit SHALL last exactly max(div_i,4) cycles; div_i SHALL be latched when a frame starts, and changes mid-frame SHALL be ignored.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- IDLE->START when the FIFO is non-empty; the pop happens on the same edge.
- START->DATA after one bit time.
- DATA->PARITY (PARITY_EN=1) or DATA->STOP after 8 bits; a 3-bit index wraps 7->0.
- PARITY->STOP after one bit time.
- STOP->START (pop) if the FIFO is non-empty, else STOP->IDLE, at the end of the stop bit.
REQ-016 tx_o SHALL be a registered output; a pop at edge k SHALL drive tx_o=0 from edge k.
REQ-017 From IDLE with an empty FIFO, a handshake at edge k SHALL produce the pop at edge k+1, so tx_o falls at edge k+1.
REQ-018 Back-to-back frames SHALL have no idle gap: the stop bit is exactly one bit time.
REQ-019 ready_o SHALL equal (level < DEPTH) and SHALL be combinational from the registered level.
REQ-020 A push and a pop in the same cycle SHALL leave level unchanged.
REQ-021 When the FIFO is full, push and pop SHALL NOT occur in the same cycle, because ready_o=0.
REQ-022 FIFO pointers SHALL be $clog2(DEPTH) bits and wrap naturally.
REQ-023 level_o SHALL range 0..DEPTH.
REQ-024 A push with valid_i=0 or ready_o=0 SHALL have no effect; data_i SHALL be ignored when no handshake occurs.
REQ-025 busy_o SHALL be 0 only in IDLE with level_o=0.

Reset
REQ-026 While rst_i=1 at an edge, the block SHALL set tx_o=1, ready_o=1, busy_o=0, level_o=0, FSM=IDLE, and clear all counters.
REQ-027 Reset mid-frame SHALL abandon the frame and discard all FIFO contents, and tx_o SHALL be high from that edge.
REQ-028 A handshake in a cycle with rst_i=1 SHALL be discarded.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum, MIN_DIV=4, and the frame bit-count constants.
REQ-030 Storage SHALL be the sub-module uart_tx_fifo: synchronous FIFO, same clk_i/rst_i, push/pop/level, output data is the head entry (first-word fall-through).
REQ-031 The FSM, baud counter, bit index and shift register SHALL reside in uart_tx_buf.

Verification
REQ-032 div_i=8, push 0x55 -> tx_o sequence 0,1,0,1,0,1,0,1,0,1, each bit 8 cycles, 80 cycles total; a uart_sim instance at the matching baud prints 'U'.
REQ-033 PARITY_EN=1, div_i=8, push 0x07 -> parity bit=1, frame 88 cycles; push 0x03 -> parity bit=0.
REQ-034 DEPTH=8, valid_i held high with 10 bytes -> 9 accepted immediately (1 popped + 8 stored), ready_o=0, level_o=8; the 10th byte is accepted at the end of frame 1; output frames are contiguous with no idle cycles.
REQ-035 div_i=2 -> bit time is 4 cycles. Changing div_i from 8 to 16 mid-frame -> the current frame stays at 8, and the next frame uses 16.
REQ-036 Pulse rst_i during data bit 3 with 4 bytes queued -> tx_o=1 and level_o=0 from that edge, and no further frames.
REQ-037 A push of 0xA5 while idle, sampled at edge k -> tx_o=0 from edge k+1, and busy_o=1 from edge k until the end of the stop bit.
